// File: rtl/control_status_register_file_pkg.sv
// Shared CSR address map and decode helpers for the CSR register file.
// No ports; imported by the interface, the counter and the top.
package control_status_register_file_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CSR_ADDR_W = 12;

    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_TIME      = 12'hC01;
    localparam logic [11:0] CSR_TIMEH     = 12'hC81;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;

    // mstatus fields: MPP is hardwired to machine mode, MIE/MPIE are the only state.
    localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;
    localparam int unsigned MSTATUS_MIE   = 3;
    localparam int unsigned MSTATUS_MPIE  = 7;

    // True for every address this register file decodes.
    function automatic logic csr_implemented(input logic [CSR_ADDR_W-1:0] idx);
        case (idx)
            CSR_CYCLE, CSR_CYCLEH, CSR_TIME, CSR_TIMEH, CSR_INSTRET, CSR_INSTRETH,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_MSTATUS, CSR_MISA, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    // Top two address bits 2'b11 mark the architecturally read-only space.
    function automatic logic csr_read_only(input logic [CSR_ADDR_W-1:0] idx);
        return idx[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/control_status_register_file_if.sv
// CSR access bus between the CSR ALU side (master) and the register file (slave).
// Signals: read index/data, write enable/index/data, retire pulse, illegal flag.
interface control_status_register_file_if;
    import control_status_register_file_pkg::*;

    logic [CSR_ADDR_W-1:0] csr_read_index;
    logic [XLEN-1:0]       csr_read_data;
    logic                  write_enable;
    logic [CSR_ADDR_W-1:0] csr_write_index;
    logic [XLEN-1:0]       csr_write_data;
    logic                  instret_pulse;
    logic                  illegal_csr;

    modport master (
        output csr_read_index, write_enable, csr_write_index, csr_write_data, instret_pulse,
        input  csr_read_data, illegal_csr
    );

    modport slave (
        input  csr_read_index, write_enable, csr_write_index, csr_write_data, instret_pulse,
        output csr_read_data, illegal_csr
    );

endinterface

// File: rtl/control_status_register_file_csr_counter_64.sv
// 64-bit counter with independently writable 32-bit halves.
// Ports: clk, reset (async high), increment, write_lo, write_hi, write_data, value.
module csr_counter_64
    import control_status_register_file_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            increment,
    input  logic            write_lo,
    input  logic            write_hi,
    input  logic [XLEN-1:0] write_data,
    output logic [63:0]     value
);

    logic [63:0]     value_inc;
    logic [XLEN-1:0] lo_inc;

    // Full-width increment carries into hi; lo-only increment is used when hi is written.
    always_comb begin
        value_inc = value + 64'(increment);
        lo_inc    = value[31:0] + 32'(increment);
    end

    // A lo write drops this cycle's increment; a hi write keeps the lo increment but not its carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= 64'd0;
        end else if (write_lo) begin
            value <= {value[63:32], write_data};
        end else if (write_hi) begin
            value <= {write_data, lo_inc};
        end else begin
            value <= value_inc;
        end
    end

endmodule

// File: rtl/control_status_register_file.sv
// Architectural CSR storage: counters, machine-mode registers, read mux, illegal-access flag.
// Ports: clk, reset (async high), bus (slave side of the CSR access interface).
module control_status_register_file
    import control_status_register_file_pkg::*;
#(
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          COUNTERS_ON = 1'b1
)
(
    input  logic                          clk,
    input  logic                          reset,
    control_status_register_file_if.slave bus
);

    logic            write_ok;
    logic            counters_en;
    logic [63:0]     cycle_value;
    logic [63:0]     instret_value;
    logic            mie;
    logic            mpie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mstatus_value;

    // Illegal writes (unimplemented or read-only target) never reach state.
    always_comb begin
        counters_en = COUNTERS_ON;
        write_ok    = bus.write_enable
                      && csr_implemented(bus.csr_write_index)
                      && !csr_read_only(bus.csr_write_index);
    end

    always_comb begin
        bus.illegal_csr = !csr_implemented(bus.csr_read_index)
                          || (bus.write_enable
                              && (!csr_implemented(bus.csr_write_index)
                                  || csr_read_only(bus.csr_write_index)));
    end

    // Disabled counters neither count nor take writes, so they stay at zero.
    csr_counter_64 u_cycle (
        .clk        (clk),
        .reset      (reset),
        .increment  (counters_en),
        .write_lo   (counters_en && write_ok && bus.csr_write_index == CSR_MCYCLE),
        .write_hi   (counters_en && write_ok && bus.csr_write_index == CSR_MCYCLEH),
        .write_data (bus.csr_write_data),
        .value      (cycle_value)
    );

    csr_counter_64 u_instret (
        .clk        (clk),
        .reset      (reset),
        .increment  (counters_en && bus.instret_pulse),
        .write_lo   (counters_en && write_ok && bus.csr_write_index == CSR_MINSTRET),
        .write_hi   (counters_en && write_ok && bus.csr_write_index == CSR_MINSTRETH),
        .write_data (bus.csr_write_data),
        .value      (instret_value)
    );

    // Machine-mode register commits; WARL masks applied on the way in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else if (write_ok) begin
            case (bus.csr_write_index)
                CSR_MSTATUS: begin
                    mie  <= bus.csr_write_data[MSTATUS_MIE];
                    mpie <= bus.csr_write_data[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec    <= {bus.csr_write_data[31:2], 1'b0, bus.csr_write_data[0]};
                CSR_MSCRATCH: mscratch <= bus.csr_write_data;
                CSR_MEPC:     mepc     <= {bus.csr_write_data[31:2], 2'b00};
                CSR_MCAUSE:   mcause   <= bus.csr_write_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        mstatus_value                = MSTATUS_MPP_M;
        mstatus_value[MSTATUS_MIE]   = mie;
        mstatus_value[MSTATUS_MPIE]  = mpie;
    end

    // Zero-latency read mux; a same-cycle write is not forwarded.
    always_comb begin
        bus.csr_read_data = '0;
        case (bus.csr_read_index)
            CSR_CYCLE, CSR_TIME, CSR_MCYCLE:       bus.csr_read_data = cycle_value[31:0];
            CSR_CYCLEH, CSR_TIMEH, CSR_MCYCLEH:    bus.csr_read_data = cycle_value[63:32];
            CSR_INSTRET, CSR_MINSTRET:             bus.csr_read_data = instret_value[31:0];
            CSR_INSTRETH, CSR_MINSTRETH:           bus.csr_read_data = instret_value[63:32];
            CSR_MSTATUS:                           bus.csr_read_data = mstatus_value;
            CSR_MISA:                              bus.csr_read_data = MISA_VALUE;
            CSR_MTVEC:                             bus.csr_read_data = mtvec;
            CSR_MSCRATCH:                          bus.csr_read_data = mscratch;
            CSR_MEPC:                              bus.csr_read_data = mepc;
            CSR_MCAUSE:                            bus.csr_read_data = mcause;
            default:                               bus.csr_read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_control_status_register_file.sv
// Self-checking bench: a value-level CSR model checked every negedge, plus directed literal checks.
module tb_control_status_register_file;

    localparam logic [31:0] MISA = 32'h4000_0100;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   cmp_on;

    control_status_register_file_if bus ();

    control_status_register_file #(
        .MISA_VALUE  (MISA),
        .MTVEC_RESET (32'h0000_0000),
        .COUNTERS_ON (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state kept as plain architectural values.
    logic [63:0] m_cycle;
    logic [63:0] m_instret;
    logic        m_mie;
    logic        m_mpie;
    logic [31:0] m_mtvec;
    logic [31:0] m_mscratch;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;

    function automatic bit is_impl(input logic [11:0] idx);
        logic [11:0] known [16] = '{12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82,
                                    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h300, 12'h301,
                                    12'h305, 12'h340, 12'h341, 12'h342};
        for (int i = 0; i < 16; i++) if (known[i] == idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit legal_write(input logic we, input logic [11:0] idx);
        return we && is_impl(idx) && (idx[11:10] != 2'b11);
    endfunction

    function automatic logic [31:0] exp_read(input logic [11:0] idx);
        case (idx)
            12'hC00, 12'hC01, 12'hB00: return m_cycle[31:0];
            12'hC80, 12'hC81, 12'hB80: return m_cycle[63:32];
            12'hC02, 12'hB02:          return m_instret[31:0];
            12'hC82, 12'hB82:          return m_instret[63:32];
            12'h300:                   return 32'h0000_1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
            12'h301:                   return MISA;
            12'h305:                   return m_mtvec;
            12'h340:                   return m_mscratch;
            12'h341:                   return m_mepc;
            12'h342:                   return m_mcause;
            default:                   return 32'h0;
        endcase
    endfunction

    function automatic logic exp_illegal(input logic [11:0] ridx, input logic we, input logic [11:0] widx);
        return !is_impl(ridx) || (we && (!is_impl(widx) || widx[11:10] == 2'b11));
    endfunction

    // Model update: each counter ticks, a lo write replaces lo and drops the tick,
    // a hi write replaces hi while lo still ticks without carrying.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cycle    <= 64'd0;
            m_instret  <= 64'd0;
            m_mie      <= 1'b0;
            m_mpie     <= 1'b0;
            m_mtvec    <= 32'h0;
            m_mscratch <= 32'h0;
            m_mepc     <= 32'h0;
            m_mcause   <= 32'h0;
        end else begin
            if (legal_write(bus.write_enable, bus.csr_write_index) && bus.csr_write_index == 12'hB00)
                m_cycle <= {m_cycle[63:32], bus.csr_write_data};
            else if (legal_write(bus.write_enable, bus.csr_write_index) && bus.csr_write_index == 12'hB80)
                m_cycle <= {bus.csr_write_data, m_cycle[31:0] + 32'd1};
            else
                m_cycle <= m_cycle + 64'd1;

            if (legal_write(bus.write_enable, bus.csr_write_index) && bus.csr_write_index == 12'hB02)
                m_instret <= {m_instret[63:32], bus.csr_write_data};
            else if (legal_write(bus.write_enable, bus.csr_write_index) && bus.csr_write_index == 12'hB82)
                m_instret <= {bus.csr_write_data, m_instret[31:0] + 32'(bus.instret_pulse)};
            else
                m_instret <= m_instret + 64'(bus.instret_pulse);

            if (legal_write(bus.write_enable, bus.csr_write_index)) begin
                case (bus.csr_write_index)
                    12'h300: begin
                        m_mie  <= bus.csr_write_data[3];
                        m_mpie <= bus.csr_write_data[7];
                    end
                    12'h305: m_mtvec    <= bus.csr_write_data & 32'hFFFF_FFFD;
                    12'h340: m_mscratch <= bus.csr_write_data;
                    12'h341: m_mepc     <= bus.csr_write_data & 32'hFFFF_FFFC;
                    12'h342: m_mcause   <= bus.csr_write_data;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_read_data", bus.csr_read_data, exp_read(bus.csr_read_index));
            check("model_illegal", 32'(bus.illegal_csr),
                  32'(exp_illegal(bus.csr_read_index, bus.write_enable, bus.csr_write_index)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [11:0] idx, input logic [31:0] exp);
        bus.csr_read_index = idx;
        #1;
        check(name, bus.csr_read_data, exp);
    endtask

    task automatic wr(input logic [11:0] idx, input logic [31:0] data);
        bus.write_enable    = 1'b1;
        bus.csr_write_index = idx;
        bus.csr_write_data  = data;
    endtask

    task automatic wr_off();
        bus.write_enable    = 1'b0;
        bus.csr_write_index = 12'h000;
        bus.csr_write_data  = 32'h0;
    endtask

    initial begin
        checks              = 0;
        errors              = 0;
        cmp_on              = 1'b0;
        reset               = 1'b1;
        bus.csr_read_index  = 12'hC00;
        bus.instret_pulse   = 1'b0;
        wr_off();
        tick();
        tick();
        reset  = 1'b0;
        cmp_on = 1'b1;

        // Idle counting from reset.
        repeat (5) tick();
        rd("cycle_after_5", 12'hC00, 32'd5);
        rd("cycleh_after_5", 12'hC80, 32'd0);
        rd("misa", 12'h301, MISA);

        // lo then hi write, then the carry into hi.
        wr(12'hB00, 32'hFFFF_FFFE);
        tick();
        wr(12'hB80, 32'h0);
        tick();
        wr_off();
        tick();
        rd("carry_lo", 12'hC00, 32'h0);
        rd("carry_hi", 12'hC80, 32'h1);

        wr(12'h305, 32'h8000_0007);
        tick();
        wr_off();
        rd("mtvec_mask", 12'h305, 32'h8000_0005);

        wr(12'h300, 32'hFFFF_FFFF);
        tick();
        wr_off();
        rd("mstatus_mask", 12'h300, 32'h0000_1888);

        // Write into read-only space: flagged, counter keeps counting.
        wr(12'hC00, 32'h0000_1234);
        rd("ro_write_old", 12'hC00, 32'd2);
        check("ro_write_illegal", 32'(bus.illegal_csr), 32'd1);
        tick();
        wr_off();
        rd("ro_write_after", 12'hC00, 32'd3);

        rd("unimpl_data", 12'h7C0, 32'h0);
        check("unimpl_illegal", 32'(bus.illegal_csr), 32'd1);

        // misa write accepted and ignored.
        wr(12'h301, 32'h0);
        rd("misa_write_legal_data", 12'h301, MISA);
        check("misa_write_legal", 32'(bus.illegal_csr), 32'd0);
        tick();
        wr_off();
        rd("misa_unchanged", 12'h301, MISA);

        // Three retirements in four cycles.
        bus.instret_pulse = 1'b1; tick();
        bus.instret_pulse = 1'b1; tick();
        bus.instret_pulse = 1'b0; tick();
        bus.instret_pulse = 1'b1; tick();
        bus.instret_pulse = 1'b0;
        rd("instret_3", 12'hC02, 32'd3);
        rd("minstret_3", 12'hB02, 32'd3);

        // Read-during-write returns the old value.
        wr(12'h340, 32'h0000_00A5);
        rd("mscratch_old", 12'h340, 32'h0);
        tick();
        wr_off();
        rd("mscratch_new", 12'h340, 32'h0000_00A5);

        wr(12'h341, 32'h0000_1237);
        tick();
        wr_off();
        rd("mepc_mask", 12'h341, 32'h0000_1234);

        // Hi write discards the lo carry.
        wr(12'hB02, 32'hFFFF_FFFF);
        tick();
        wr(12'hB82, 32'h0000_0005);
        bus.instret_pulse = 1'b1;
        tick();
        bus.instret_pulse = 1'b0;
        wr_off();
        rd("instret_nocarry_lo", 12'hC02, 32'h0);
        rd("instret_nocarry_hi", 12'hC82, 32'h5);

        // 64-bit wrap.
        wr(12'hB80, 32'hFFFF_FFFF);
        tick();
        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        wr_off();
        tick();
        rd("wrap_lo", 12'hC00, 32'h0);
        rd("wrap_hi", 12'hC80, 32'h0);

        // Reset mid-count takes effect immediately.
        repeat (3) tick();
        bus.csr_read_index = 12'hC00;
        wr(12'h340, 32'h0000_5555);
        reset = 1'b1;
        rd("reset_cycle", 12'hC00, 32'h0);
        rd("reset_mscratch", 12'h340, 32'h0);
        rd("reset_mstatus", 12'h300, 32'h0000_1800);
        tick();
        wr_off();
        tick();
        reset = 1'b0;
        bus.csr_read_index = 12'hC00;
        repeat (4) tick();
        rd("count_after_reset", 12'hC00, 32'd4);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
